sram_wr_formatter: RTL and testbench



---
 rtl/sram_cfg_pkg.sv | 31 +++
 rtl/sram_wr_formatter_if.sv | 38 +++
 rtl/sram_wr_lane_place.sv | 48 ++++
 rtl/sram_wr_formatter.sv | 164 ++++++++++++++++
 tb/tb_sram_wr_formatter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_cfg_pkg.sv
// ---------------------------------------------------------------------------
// sram_cfg_pkg
// Shared SRAM lane configuration definitions, used by both the read-side lane
// mux and the write-side formatter.
//   CONF_*      : width configuration codes carried on the 2-bit conf input
//   wr_state_e  : write formatter FSM states
//   expand_mask : widens a 4-bit byte mask to a 32-bit bit mask
// ---------------------------------------------------------------------------
package sram_cfg_pkg;

    localparam logic [1:0] CONF_32   = 2'b00;
    localparam logic [1:0] CONF_16   = 2'b01;
    localparam logic [1:0] CONF_8    = 2'b10;
    localparam logic [1:0] CONF_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WRITE    = 2'd3
    } wr_state_e;

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = {8{m[i]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_wr_formatter_if.sv
// ---------------------------------------------------------------------------
// sram_wr_formatter_if
// Bundles the bus-side write request port and the SRAM macro port of the
// write formatter.
//   conf, req_*   : width config and valid/ready write request handshake
//   req_err       : reserved-config error pulse
//   mem_*         : SRAM enable, write/read select, word address, data, mask
//                   and read data
// Modports:
//   slave  : the formatter (consumes requests, drives the SRAM port)
//   master : the environment (issues requests, models the SRAM)
// ---------------------------------------------------------------------------
interface sram_wr_formatter_if #(
    parameter int ADDR_W = 8
);
    logic [1:0]        conf;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata;

    modport slave (
        input  conf, req_valid, req_addr, req_wdata, mem_rdata,
        output req_ready, req_err, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output conf, req_valid, req_addr, req_wdata, mem_rdata,
        input  req_ready, req_err, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/sram_wr_lane_place.sv
// ---------------------------------------------------------------------------
// sram_wr_lane_place
// Purely combinational lane placement for one write element.
//   conf    in  2   width configuration
//   addr_lo in  2   low element-address bits (lane / byte select)
//   wdata   in  32  right-justified write data
//   placed  out 32  data moved into its lane, other lanes zero
//   mask    out 4   byte enables of the selected lane (0 for reserved conf)
// ---------------------------------------------------------------------------
module sram_wr_lane_place
    import sram_cfg_pkg::*;
(
    input  logic [1:0]  conf,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] placed,
    output logic [3:0]  mask
);

    always_comb begin
        placed = '0;
        mask   = '0;
        case (conf)
            CONF_32: begin
                placed = wdata;
                mask   = 4'b1111;
            end
            CONF_16: begin
                if (addr_lo[0]) begin
                    placed = {wdata[15:0], 16'h0000};
                    mask   = 4'b1100;
                end else begin
                    placed = {16'h0000, wdata[15:0]};
                    mask   = 4'b0011;
                end
            end
            CONF_8: begin
                placed = {24'h000000, wdata[7:0]} << {addr_lo, 3'b000};
                mask   = 4'b0001 << addr_lo;
            end
            default: begin
                placed = '0;
                mask   = '0;
            end
        endcase
    end

endmodule

// File: rtl/sram_wr_formatter.sv
// ---------------------------------------------------------------------------
// sram_wr_formatter
// Write-side lane formatter between the bus write port and the SRAM macro.
// Places 32/16/8-bit elements into their lane of a 32-bit word, generates the
// word address and byte mask, and for mask-less macros (USE_RMW=1) performs a
// read-merge-write for narrow writes.
//   clk   in  clock
//   rst_n in  synchronous active-low reset
//   bus   sram_wr_formatter_if.slave: request handshake + SRAM port
// Parameters: ADDR_W word-address width, USE_RMW read-merge-write enable,
// RD_LAT read latency in cycles (1..3).
// ---------------------------------------------------------------------------
module sram_wr_formatter
    import sram_cfg_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int USE_RMW = 0,
    parameter int RD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_wr_formatter_if.slave   bus
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    wr_state_e         state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [31:0]       placed_q, placed_d;
    logic [3:0]        mask_q, mask_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic              req_err_q, req_err_d;

    logic              req_ready;
    logic              accept;
    logic [ADDR_W-1:0] req_word;
    logic [31:0]       pl_data;
    logic [3:0]        pl_mask;
    logic [31:0]       merged;

    sram_wr_lane_place u_lane_place (
        .conf    (bus.conf),
        .addr_lo (bus.req_addr[1:0]),
        .wdata   (bus.req_wdata),
        .placed  (pl_data),
        .mask    (pl_mask)
    );

    assign req_ready = (state_q == IDLE) || (state_q == WRITE);
    assign accept    = bus.req_valid && req_ready;

    // Element address to word address: drop the lane-select bits of the
    // configured width; higher unused address bits fall off the top.
    always_comb begin
        case (bus.conf)
            CONF_16: req_word = bus.req_addr[ADDR_W:1];
            CONF_8:  req_word = bus.req_addr[ADDR_W+1:2];
            default: req_word = bus.req_addr[ADDR_W-1:0];
        endcase
    end

    // Next-state and next-output logic. Request fields are captured already
    // placed so later conf changes cannot disturb an in-flight RMW; the
    // captured byte mask selects which read bytes get replaced in the merge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        placed_d    = placed_q;
        mask_d      = mask_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wmask_d = '0;
        req_err_d   = 1'b0;
        merged      = (bus.mem_rdata & ~expand_mask(mask_q)) | placed_q;

        case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (accept) begin
                    if (bus.conf == CONF_RSVD) begin
                        req_err_d = 1'b1;
                    end else begin
                        word_d     = req_word;
                        placed_d   = pl_data;
                        mask_d     = pl_mask;
                        mem_en_d   = 1'b1;
                        mem_addr_d = req_word;
                        if (USE_RMW == 0 || bus.conf == CONF_32) begin
                            state_d     = WRITE;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = pl_data;
                            mem_wmask_d = (USE_RMW != 0) ? 4'b1111 : pl_mask;
                        end else begin
                            state_d = RD_ISSUE;
                        end
                    end
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                cnt_d   = WAIT_INIT;
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d     = WRITE;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_q;
                    mem_wdata_d = merged;
                    mem_wmask_d = 4'b1111;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset wins over any pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            placed_q    <= '0;
            mask_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            req_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            placed_q    <= placed_d;
            mask_q      <= mask_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            req_err_q   <= req_err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.req_err   = req_err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_sram_wr_formatter.sv
// ---------------------------------------------------------------------------
// tb_sram_wr_formatter
// Drives two formatter instances: dut0 with a byte-masked macro (USE_RMW=0)
// and dut1 with a mask-less macro (USE_RMW=1, RD_LAT=2) backed by a simple
// SRAM model. A per-cycle expectation table is filled from the element
// addressing rules when requests are accepted and compared every cycle.
// ---------------------------------------------------------------------------
module tb_sram_wr_formatter;
    import sram_cfg_pkg::*;

    localparam int ADDR_W = 8;
    localparam int LAT1   = 2;
    localparam int NCYC   = 128;

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sram_wr_formatter_if #(.ADDR_W(ADDR_W)) if0 ();
    sram_wr_formatter_if #(.ADDR_W(ADDR_W)) if1 ();

    sram_wr_formatter #(.ADDR_W(ADDR_W), .USE_RMW(0), .RD_LAT(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (if0)
    );

    sram_wr_formatter #(.ADDR_W(ADDR_W), .USE_RMW(1), .RD_LAT(LAT1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (if1)
    );

    // SRAM environment: masked writes, RD_LAT-deep read pipeline.
    logic [31:0] env_mem [2][256];
    logic [31:0] rd_pipe [LAT1];

    function automatic logic [31:0] bytes32(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    always @(posedge clk) begin
        if (if0.mem_en && if0.mem_we)
            env_mem[0][if0.mem_addr] <= (env_mem[0][if0.mem_addr] & ~bytes32(if0.mem_wmask)) |
                                        (if0.mem_wdata & bytes32(if0.mem_wmask));
        if (if1.mem_en && if1.mem_we)
            env_mem[1][if1.mem_addr] <= (env_mem[1][if1.mem_addr] & ~bytes32(if1.mem_wmask)) |
                                        (if1.mem_wdata & bytes32(if1.mem_wmask));
        if (if1.mem_en && !if1.mem_we)
            rd_pipe[0] <= env_mem[1][if1.mem_addr];
        for (int i = 1; i < LAT1; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign if0.mem_rdata = 32'h0;
    assign if1.mem_rdata = rd_pipe[LAT1-1];

    // Expectation table, indexed by DUT and cycle.
    logic        e_en    [2][NCYC];
    logic        e_we    [2][NCYC];
    logic [7:0]  e_addr  [2][NCYC];
    logic [31:0] e_wdata [2][NCYC];
    logic [3:0]  e_mask  [2][NCYC];
    logic        e_merge [2][NCYC];
    logic [3:0]  e_bmask [2][NCYC];
    logic        e_err   [2][NCYC];
    logic        e_ready [2][NCYC];
    logic [31:0] ref_mem [2][256];
    bit          cmp_on = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic void clearFrom(input int d, input int k0);
        for (int k = k0; k < NCYC; k++) begin
            e_en[d][k]    = 1'b0;
            e_we[d][k]    = 1'b0;
            e_addr[d][k]  = '0;
            e_wdata[d][k] = '0;
            e_mask[d][k]  = '0;
            e_merge[d][k] = 1'b0;
            e_bmask[d][k] = '0;
            e_err[d][k]   = 1'b0;
            e_ready[d][k] = 1'b1;
        end
    endfunction

    // Model of an accepted request issued in cycle c.
    function automatic void modelAccept(input int d, input int c, input logic [1:0] conf,
                                        input logic [9:0] addr, input logic [31:0] wdata);
        int          a;
        int          word;
        logic [31:0] placed;
        logic [3:0]  bm;
        int          lat;
        a      = int'(addr);
        word   = 0;
        placed = '0;
        bm     = '0;
        lat    = (d == 1) ? LAT1 : 1;
        case (conf)
            2'b00: begin word = a % 256; placed = wdata; bm = 4'hF; end
            2'b01: begin
                word = (a / 2) % 256;
                if (a % 2 == 1) begin placed = (wdata & 32'hFFFF) << 16; bm = 4'b1100; end
                else begin placed = wdata & 32'hFFFF; bm = 4'b0011; end
            end
            2'b10: begin
                word   = (a / 4) % 256;
                placed = (wdata & 32'hFF) << (8 * (a % 4));
                bm     = 4'b0001 << (a % 4);
            end
            default: ;
        endcase
        if (conf == 2'b11) begin
            e_err[d][c+1] = 1'b1;
        end else if (d == 0 || conf == 2'b00) begin
            e_en[d][c+1]    = 1'b1;
            e_we[d][c+1]    = 1'b1;
            e_addr[d][c+1]  = 8'(word);
            e_wdata[d][c+1] = placed;
            e_mask[d][c+1]  = (d == 1) ? 4'hF : bm;
        end else begin
            e_en[d][c+1]   = 1'b1;
            e_we[d][c+1]   = 1'b0;
            e_addr[d][c+1] = 8'(word);
            for (int k = c + 1; k <= c + 1 + lat; k++) e_ready[d][k] = 1'b0;
            e_en[d][c+lat+2]    = 1'b1;
            e_we[d][c+lat+2]    = 1'b1;
            e_addr[d][c+lat+2]  = 8'(word);
            e_wdata[d][c+lat+2] = placed;
            e_merge[d][c+lat+2] = 1'b1;
            e_bmask[d][c+lat+2] = bm;
            e_mask[d][c+lat+2]  = 4'hF;
        end
    endfunction

    task automatic applyStimulus(input int d, input logic [1:0] conf, input logic [9:0] addr,
                                 input logic [31:0] wdata);
        if (d == 0) begin
            if0.conf = conf; if0.req_addr = addr; if0.req_wdata = wdata; if0.req_valid = 1'b1;
        end else begin
            if1.conf = conf; if1.req_addr = addr; if1.req_wdata = wdata; if1.req_valid = 1'b1;
        end
        if (e_ready[d][cyc]) modelAccept(d, cyc, conf, addr, wdata);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if0.req_valid = 1'b0;
        if1.req_valid = 1'b0;
    endtask

    task automatic compareDut(input int d, input logic en, input logic we, input logic [7:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wmask,
                              input logic err, input logic ready);
        int          c;
        string       tag;
        logic [31:0] exp_data;
        c   = cyc;
        tag = $sformatf("dut%0d@%0d", d, c);
        checkOutput({tag, "_ready"}, 32'(ready), 32'(e_ready[d][c]));
        checkOutput({tag, "_err"}, 32'(err), 32'(e_err[d][c]));
        checkOutput({tag, "_en"}, 32'(en), 32'(e_en[d][c]));
        if (e_en[d][c]) begin
            checkOutput({tag, "_we"}, 32'(we), 32'(e_we[d][c]));
            checkOutput({tag, "_addr"}, 32'(addr), 32'(e_addr[d][c]));
            if (e_we[d][c]) begin
                if (e_merge[d][c])
                    exp_data = (ref_mem[d][e_addr[d][c]] & ~bytes32(e_bmask[d][c])) | e_wdata[d][c];
                else
                    exp_data = e_wdata[d][c];
                checkOutput({tag, "_wdata"}, wdata, exp_data);
                checkOutput({tag, "_wmask"}, 32'(wmask), 32'(e_mask[d][c]));
                ref_mem[d][e_addr[d][c]] = (ref_mem[d][e_addr[d][c]] & ~bytes32(e_mask[d][c])) |
                                           (exp_data & bytes32(e_mask[d][c]));
            end
        end else begin
            checkOutput({tag, "_wdata_idle"}, wdata, 32'h0);
            checkOutput({tag, "_wmask_idle"}, 32'(wmask), 32'h0);
        end
    endtask

    // Per-cycle comparison against the expectation table.
    always @(negedge clk) begin
        if (cmp_on && cyc >= 1 && cyc < NCYC) begin
            compareDut(0, if0.mem_en, if0.mem_we, if0.mem_addr, if0.mem_wdata, if0.mem_wmask,
                       if0.req_err, if0.req_ready);
            compareDut(1, if1.mem_en, if1.mem_we, if1.mem_addr, if1.mem_wdata, if1.mem_wmask,
                       if1.req_err, if1.req_ready);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  t_conf [6];
        logic [9:0]  t_addr [6];
        logic [31:0] t_data [6];

        t_conf = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10};
        t_addr = '{10'h004, 10'h000, 10'h3FF, 10'h3AB, 10'h2FF, 10'h002};
        t_data = '{32'h0000CAFE, 32'h00000011, 32'h000000EE, 32'h01234567, 32'h99997777, 32'hFFFFFF5C};

        for (int d = 0; d < 2; d++) begin
            clearFrom(d, 0);
            for (int w = 0; w < 256; w++) begin
                ref_mem[d][w] = 32'h11223344 ^ (32'(w) * 32'h01010101);
                env_mem[d][w] = 32'h11223344 ^ (32'(w) * 32'h01010101);
            end
        end
        for (int i = 0; i < LAT1; i++) rd_pipe[i] = '0;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        if0.req_valid = 1'b0; if0.conf = 2'b00; if0.req_addr = '0; if0.req_wdata = '0;
        if1.req_valid = 1'b0; if1.conf = 2'b00; if1.req_addr = '0; if1.req_wdata = '0;
        cmp_on = 1'b1;

        @(posedge clk); #1;
        tick();
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        @(negedge clk);
        checkOutput("rst_en0", 32'(if0.mem_en), 32'h0);
        checkOutput("rst_wdata1", if1.mem_wdata, 32'h0);
        checkOutput("rst_ready1", 32'(if1.req_ready), 32'h1);
        checkOutput("rst_err0", 32'(if0.req_err), 32'h0);

        // 8-bit write, byte 1 of word 3
        tick();
        applyStimulus(0, 2'b10, 10'h00D, 32'h000000AB);
        tick();
        @(negedge clk);
        checkOutput("b8_en", 32'(if0.mem_en), 32'h1);
        checkOutput("b8_we", 32'(if0.mem_we), 32'h1);
        checkOutput("b8_addr", 32'(if0.mem_addr), 32'h03);
        checkOutput("b8_wdata", if0.mem_wdata, 32'h0000AB00);
        checkOutput("b8_wmask", 32'(if0.mem_wmask), 32'h2);

        // back-to-back 16-bit then 32-bit
        tick();
        applyStimulus(0, 2'b01, 10'h005, 32'h00001234);
        tick();
        applyStimulus(0, 2'b00, 10'h007, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("h16_addr", 32'(if0.mem_addr), 32'h02);
        checkOutput("h16_wdata", if0.mem_wdata, 32'h12340000);
        checkOutput("h16_wmask", 32'(if0.mem_wmask), 32'hC);
        tick();
        @(negedge clk);
        checkOutput("w32_addr", 32'(if0.mem_addr), 32'h07);
        checkOutput("w32_wdata", if0.mem_wdata, 32'hDEADBEEF);
        checkOutput("w32_wmask", 32'(if0.mem_wmask), 32'hF);

        // streaming table of lanes and unused high address bits
        for (int i = 0; i < 6; i++) begin
            tick();
            applyStimulus(0, t_conf[i], t_addr[i], t_data[i]);
        end
        tick();
        tick();

        // reserved config
        applyStimulus(0, 2'b11, 10'h010, 32'h00000001);
        tick();
        @(negedge clk);
        checkOutput("rsvd_err", 32'(if0.req_err), 32'h1);
        checkOutput("rsvd_en", 32'(if0.mem_en), 32'h0);
        checkOutput("rsvd_ready", 32'(if0.req_ready), 32'h1);
        tick();
        @(negedge clk);
        checkOutput("rsvd_err_end", 32'(if0.req_err), 32'h0);

        // RMW 8-bit write into word 0 (0x11223344)
        tick();
        applyStimulus(1, 2'b10, 10'h001, 32'h0000005A);
        tick();
        @(negedge clk);
        checkOutput("rmw_rd_en", 32'(if1.mem_en), 32'h1);
        checkOutput("rmw_rd_we", 32'(if1.mem_we), 32'h0);
        checkOutput("rmw_rd_addr", 32'(if1.mem_addr), 32'h00);
        checkOutput("rmw_rd_ready", 32'(if1.req_ready), 32'h0);
        tick();
        applyStimulus(1, 2'b00, 10'h003, 32'hFFFFFFFF);
        @(negedge clk);
        checkOutput("rmw_wait_ready", 32'(if1.req_ready), 32'h0);
        tick();
        tick();
        applyStimulus(1, 2'b01, 10'h001, 32'h0000BEEF);
        @(negedge clk);
        checkOutput("rmw_wr_en", 32'(if1.mem_en), 32'h1);
        checkOutput("rmw_wr_wdata", if1.mem_wdata, 32'h11225A44);
        checkOutput("rmw_wr_wmask", 32'(if1.mem_wmask), 32'hF);
        tick();
        tick();
        tick();
        tick();
        applyStimulus(1, 2'b00, 10'h005, 32'hA5A5A5A5);
        @(negedge clk);
        checkOutput("rmw16_wdata", if1.mem_wdata, 32'hBEEF5A44);
        tick();
        @(negedge clk);
        checkOutput("rmw32_addr", 32'(if1.mem_addr), 32'h05);
        checkOutput("rmw32_wdata", if1.mem_wdata, 32'hA5A5A5A5);
        tick();
        applyStimulus(1, 2'b11, 10'h000, 32'h0);
        tick();
        tick();

        // reset during RD_WAIT abandons the write to word 2
        applyStimulus(1, 2'b10, 10'h00B, 32'h00000077);
        tick();
        tick();
        tick();
        rst_n1 = 1'b0;
        clearFrom(1, cyc + 1);
        tick();
        rst_n1 = 1'b1;
        @(negedge clk);
        checkOutput("rst_rmw_en", 32'(if1.mem_en), 32'h0);
        checkOutput("rst_rmw_we", 32'(if1.mem_we), 32'h0);
        checkOutput("rst_rmw_wmask", 32'(if1.mem_wmask), 32'h0);
        checkOutput("rst_rmw_ready", 32'(if1.req_ready), 32'h1);
        tick();
        checkOutput("rst_rmw_mem", env_mem[1][2], 32'h13203146);
        applyStimulus(1, 2'b10, 10'h00B, 32'h00000077);
        repeat (LAT1 + 2) tick();
        @(negedge clk);
        checkOutput("rmw_retry_wdata", if1.mem_wdata, 32'h77203146);

        repeat (4) tick();
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
